// File: rtl/sonic_sync_ring_reader.sv
// sonic_sync_ring_reader: walks the Tx sync-header ring, absorbs the RAM read latency and
// hands 2-bit headers to the block encoder through a small credit-protected output FIFO.
`default_nettype none

module sonic_sync_ring_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  rd_clock,
  input  logic                  rd_reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [1:0]            ring_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [1:0]            sync_hdr,
  output logic                  sync_valid,
  input  logic                  sync_ready,
  output logic                  sync_err,
  output logic                  empty
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = 1;
  localparam logic [IW-1:0]       IDX_ONE    = 1;
  localparam logic [IW:0]         CNT_ONE    = 1;
  localparam logic [IW:0]         CNT_FULL   = FIFO_DEPTH;
  localparam logic [CW-1:0]       CREDIT_MAX = FIFO_DEPTH;

  logic [ADDR_WIDTH:0] issue_ptr;
  logic [RD_LATENCY-1:0] inflight;
  logic [1:0]          fifo_mem [FIFO_DEPTH];
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic [IW:0]         fifo_count;
  logic [CW-1:0]       credit_used;
  logic                issue;
  logic                push;
  logic                pop;

  // Every read in flight has a FIFO slot reserved, so a landing can never overflow.
  always_comb begin
    credit_used = CW'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + CW'(inflight[i]);
    end
  end

  assign issue      = enable && !flush && (wr_ptr != issue_ptr) && (credit_used < CREDIT_MAX);
  assign push       = inflight[RD_LATENCY-1] && !flush;
  assign sync_valid = (fifo_count != '0);
  assign pop        = sync_valid && sync_ready && !flush;
  assign sync_hdr   = sync_valid ? fifo_mem[rd_idx] : 2'b00;
  assign rd_address = issue_ptr[ADDR_WIDTH-1:0];
  assign empty      = (wr_ptr == issue_ptr) && (inflight == '0);

  always_ff @(posedge rd_clock or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      issue_ptr  <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
      sync_err   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 2'b00;
      end
    end else if (flush) begin
      issue_ptr  <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
      sync_err   <= 1'b0;
    end else begin
      assert (!(push && !pop && fifo_count == CNT_FULL));
      inflight <= (inflight << 1) | RD_LATENCY'(issue);
      if (issue) begin
        issue_ptr <= issue_ptr + PTR_ONE;
      end
      if (push) begin
        fifo_mem[wr_idx] <= ring_data;
        wr_idx           <= wr_idx + IDX_ONE;
        rd_ptr           <= rd_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_idx <= rd_idx + IDX_ONE;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
      // Legal sync headers are 01/10; 00 and 11 are flagged one cycle after acceptance.
      sync_err <= pop && (sync_hdr[1] ~^ sync_hdr[0]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonic_sync_ring_reader.sv
// Directed bench for sonic_sync_ring_reader with a 2-cycle-latency ring model whose
// contents are a known function of the address.
`default_nettype none

module tb_sonic_sync_ring_reader;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] rd_address;
  logic [1:0]    ring_data;
  logic [AW:0]   rd_ptr;
  logic [1:0]    sync_hdr;
  logic          sync_valid;
  logic          sync_ready;
  logic          sync_err;
  logic          empty;

  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sonic_sync_ring_reader #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .rd_clock   (clk),
    .rd_reset_n (rst_n),
    .enable     (enable),
    .flush      (flush),
    .wr_ptr     (wr_ptr),
    .rd_address (rd_address),
    .ring_data  (ring_data),
    .rd_ptr     (rd_ptr),
    .sync_hdr   (sync_hdr),
    .sync_valid (sync_valid),
    .sync_ready (sync_ready),
    .sync_err   (sync_err),
    .empty      (empty)
  );

  // Addresses 0..3 hold 01,10,00,11; higher bits scramble the pattern so skips show up.
  function automatic logic [1:0] hdr(input logic [AW-1:0] a);
    logic [1:0] idx;
    idx = a[1:0] ^ a[3:2] ^ a[5:4];
    case (idx)
      2'd0:    return 2'b01;
      2'd1:    return 2'b10;
      2'd2:    return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  always @(posedge clk) begin
    a1 <= rd_address;
    a2 <= a1;
  end
  assign ring_data = hdr(a2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          ev;
    logic          bad_prev;
    logic [1:0]    eh;
    int            got;
    logic [AW-1:0] wa [4];

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; sync_ready = 1'b0; wr_ptr = '0;
    repeat (3) step();
    chk("rst_addr", 32'(rd_address), 32'h0);
    chk("rst_rdptr", 32'(rd_ptr), 32'h0);
    chk("rst_valid", 32'(sync_valid), 32'h0);
    chk("rst_hdr", 32'(sync_hdr), 32'h0);
    chk("rst_err", 32'(sync_err), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    #3 rst_n = 1'b1;
    step();

    // One 128-bit line: 64 headers back to back, error pulses after the 3rd and 4th.
    enable = 1'b1; sync_ready = 1'b1; wr_ptr = 16'h0040;
    got = 0; bad_prev = 1'b0;
    for (int i = 0; i < 75; i++) begin
      ev = (i >= 3) && (i <= 66);
      if (i <= 64) chk("t1_addr", 32'(rd_address), 32'(i));
      chk("t1_valid", 32'(sync_valid), 32'(ev));
      chk("t1_err", 32'(sync_err), 32'(bad_prev));
      bad_prev = 1'b0;
      if (ev) begin
        eh = hdr(AW'(got));
        chk("t1_hdr", 32'(sync_hdr), 32'(eh));
        bad_prev = (eh == 2'b00) || (eh == 2'b11);
        got++;
      end
      step();
    end
    chk("t1_rdptr", 32'(rd_ptr), 32'h40);
    chk("t1_empty", 32'(empty), 32'h1);

    // Backpressure: only FIFO_DEPTH reads may issue.
    sync_ready = 1'b0; wr_ptr = 16'h00A4;
    repeat (10) step();
    chk("bp_addr", 32'(rd_address), 32'h44);
    chk("bp_rdptr", 32'(rd_ptr), 32'h44);
    chk("bp_valid", 32'(sync_valid), 32'h1);
    chk("bp_head", 32'(sync_hdr), 32'(hdr(15'h40)));
    sync_ready = 1'b1; got = 0;
    for (int i = 0; i < 200 && got < 100; i++) begin
      if (sync_valid) begin
        chk("bp_hdr", 32'(sync_hdr), 32'(hdr(AW'(32'h40 + got))));
        got++;
      end
      step();
    end
    chk("bp_count", 32'(got), 32'd100);
    chk("bp_rdptr_end", 32'(rd_ptr), 32'hA4);
    chk("bp_empty", 32'(empty), 32'h1);
    chk("bp_valid_end", 32'(sync_valid), 32'h0);

    // Flush with two reads in flight.
    sync_ready = 1'b0; wr_ptr = 16'h00AE;
    step();
    step();
    chk("fl_addr", 32'(rd_address), 32'hA6);
    flush = 1'b1;
    step();
    flush = 1'b0; enable = 1'b0; wr_ptr = '0;
    chk("fl_valid", 32'(sync_valid), 32'h0);
    chk("fl_rdptr", 32'(rd_ptr), 32'h0);
    chk("fl_addr0", 32'(rd_address), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fl_valid_after", 32'(sync_valid), 32'h0);
      chk("fl_rdptr_after", 32'(rd_ptr), 32'h0);
    end
    chk("fl_empty", 32'(empty), 32'h1);

    // Asynchronous reset pulse in the middle of a burst.
    wr_ptr = 16'h0040; enable = 1'b1; sync_ready = 1'b1;
    repeat (10) step();
    chk("ar_addr_pre", 32'(rd_address), 32'd10);
    rst_n = 1'b0; wr_ptr = '0;
    #1;
    chk("ar_addr", 32'(rd_address), 32'h0);
    chk("ar_rdptr", 32'(rd_ptr), 32'h0);
    chk("ar_valid", 32'(sync_valid), 32'h0);
    chk("ar_hdr", 32'(sync_hdr), 32'h0);
    chk("ar_err", 32'(sync_err), 32'h0);
    chk("ar_empty", 32'(empty), 32'h1);
    #2 rst_n = 1'b1; wr_ptr = 16'h0040;
    #1;
    chk("ar_restart_addr", 32'(rd_address), 32'h0);
    got = 0;
    for (int i = 0; i < 80 && got < 64; i++) begin
      if (sync_valid) begin
        chk("ar_hdr_seq", 32'(sync_hdr), 32'(hdr(AW'(got))));
        got++;
      end
      step();
    end
    chk("ar_count", 32'(got), 32'd64);
    chk("ar_rdptr_end", 32'(rd_ptr), 32'h40);

    // Wrap across 0x7FFF -> 0x0000 with the wrap bit toggling.
    wr_ptr = 16'h7FFE;
    for (int i = 0; i < 40000; i++) begin
      if (rd_ptr == 16'h7FFE && !sync_valid) break;
      step();
    end
    chk("wr_catchup", 32'(rd_ptr), 32'h7FFE);
    chk("wr_addr_start", 32'(rd_address), 32'h7FFE);
    wa[0] = 15'h7FFE; wa[1] = 15'h7FFF; wa[2] = 15'h0000; wa[3] = 15'h0001;
    wr_ptr = 16'h8002; got = 0;
    for (int i = 0; i < 12; i++) begin
      chk("wr_addr", 32'(rd_address), (i < 4) ? 32'(wa[i]) : 32'h2);
      if (sync_valid) begin
        if (got < 4) chk("wr_hdr", 32'(sync_hdr), 32'(hdr(wa[got])));
        got++;
      end
      step();
    end
    chk("wr_count", 32'(got), 32'd4);
    chk("wr_rdptr", 32'(rd_ptr), 32'h8002);
    chk("wr_empty", 32'(empty), 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
